// File: rtl/mult_control.sv
// Sequential 32x32 unsigned shift-add multiplier controller driving an external 32-bit ALU.
// One add-and-shift step per RUN cycle; the product is held after DONE until the next start.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | 32 add/shift iterations using the external ALU sum
// DONE  | one-cycle completion pulse, product stable
module mult_control #(
  parameter logic [2:0] ALU_OP_ADD = 3'b100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_cin,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic [63:0] product,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic [4:0]  count;
  logic [32:0] sum;
  logic [64:0] shifted;

  assign alu_a   = product_hi;
  assign alu_b   = mcand;
  assign alu_op  = ALU_OP_ADD;
  assign alu_cin = 1'b0;
  assign product = {product_hi, product_lo};
  assign busy    = (state == RUN) || (state == DONE);
  assign done    = (state == DONE);

  // The ALU carry becomes bit 32 of the partial sum so the shift never loses it.
  always_comb begin
    sum     = product_lo[0] ? {alu_cout, alu_result} : {1'b0, product_hi};
    shifted = {sum, product_lo};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mcand      <= 32'd0;
      product_hi <= 32'd0;
      product_lo <= 32'd0;
      count      <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand      <= multiplicand;
            product_hi <= 32'd0;
            product_lo <= multiplier;
            count      <= 5'd0;
            state      <= RUN;
          end
        end
        RUN: begin
          {product_hi, product_lo} <= shifted[64:1];
          count                    <= count + 5'd1;
          if (count == 5'd31) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: behavioural 32-bit adder as the ALU, expected products queued
// when a multiply is launched and compared when done pulses.
module tb_mult_control;

  localparam logic [2:0] ADD_CODE = 3'b100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = 32'd0;
  logic [31:0] multiplier = 32'd0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_cout;
  logic [63:0] product;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] expv;

  mult_control #(.ALU_OP_ADD(ADD_CODE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_expected(output logic [63:0] v);
    if (exp_q.size() == 0) begin
      v = 64'hDEAD_DEAD_DEAD_DEAD;
      $display("FAIL scoreboard_empty: no expected value queued");
      miscompares++;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // Launch one multiply (start for one cycle, operands scrambled afterwards) and track it.
  // lat: sample index after launch at which done was first seen (0 = never).
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [63:0] prod_done, output logic [63:0] prod_after,
                         output logic busy_after);
    start = 1'b1; multiplicand = a; multiplier = b;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    lat = 0; busy_cnt = 0; done_cnt = 0;
    prod_done = '0; prod_after = '0; busy_after = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin lat = i; prod_done = product; end
      end
      if (lat != 0 && i == lat + 1) begin
        prod_after = product; busy_after = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (product !== 64'd0) begin miscompares++; $display("FAIL reset_product: got %h want 0", product); end
    vectors++; if (alu_b !== 32'd0) begin miscompares++; $display("FAIL reset_alu_b: got %h want 0", alu_b); end
    vectors++; if (alu_op !== ADD_CODE || alu_cin !== 1'b0) begin
      miscompares++; $display("FAIL alu_ctrl: got op=%b cin=%b want op=%b cin=0", alu_op, alu_cin, ADD_CODE);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, bc, dc; logic [63:0] pd, pa; logic ba;
    run_one(32'd3, 32'd5, lat, bc, dc, pd, pa, ba);
    pop_expected(expv);
    vectors++; if (lat !== 33) begin miscompares++; $display("FAIL basic_latency: got %0d want 33", lat); end
    vectors++; if (bc !== 33) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d want 33", bc); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", dc); end
    vectors++; if (pd !== 64'h0000_0000_0000_000F || pd !== expv) begin
      miscompares++; $display("FAIL basic_product: got %h want 000000000000000f", pd);
    end
    vectors++; if (pa !== pd || ba !== 1'b0) begin
      miscompares++; $display("FAIL basic_after_done: got product=%h busy=%b want %h busy=0", pa, ba, pd);
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (product !== 64'h0000_0000_0000_000F) begin
      miscompares++; $display("FAIL basic_hold_idle: got %h want f", product);
    end
  endtask

  task automatic test_boundaries();
    int lat, bc, dc; logic [63:0] pd, pa; logic ba;
    logic [31:0] av[3] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    logic [31:0] bv[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'd2};
    logic [63:0] want[3] = '{64'hFFFF_FFFE_0000_0001, 64'd0, 64'h0000_0001_0000_0000};
    for (int k = 0; k < 3; k++) begin
      run_one(av[k], bv[k], lat, bc, dc, pd, pa, ba);
      pop_expected(expv);
      vectors++; if (pd !== want[k] || pd !== expv) begin
        miscompares++; $display("FAIL boundary_product[%0d]: got %h want %h", k, pd, want[k]);
      end
      vectors++; if (lat !== 33 || dc !== 1) begin
        miscompares++; $display("FAIL boundary_latency[%0d]: got lat=%0d dones=%0d want 33/1", k, lat, dc);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int dc = 0; int lat = 0; logic [63:0] pd = '0;
    start = 1'b1; multiplicand = 32'd11; multiplier = 32'd13;
    exp_q.push_back(64'd143);
    for (int i = 1; i <= 45; i++) begin
      tick();
      start = 1'b0;
      if (i == 10) begin start = 1'b1; multiplicand = 32'd99; multiplier = 32'd77; end
      if (done) begin dc++; if (lat == 0) begin lat = i; pd = product; end end
    end
    start = 1'b0;
    pop_expected(expv);
    vectors++; if (pd !== expv) begin miscompares++; $display("FAIL busy_start_product: got %h want %h", pd, expv); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL busy_start_done_count: got %0d want 1", dc); end
    vectors++; if (product !== 64'd143 || busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_start_idle: got product=%h busy=%b want 8f busy=0", product, busy);
    end
  endtask

  task automatic test_mid_reset();
    int dc = 0; int lat, bc, dc2; logic [63:0] pd, pa; logic ba;
    start = 1'b1; multiplicand = 32'hABCD_0123; multiplier = 32'h0F0F_F0F0;
    for (int i = 1; i <= 15; i++) begin tick(); start = 1'b0; end
    reset_n = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0 || product !== 64'd0) begin
      miscompares++; $display("FAIL midreset_state: got busy=%b product=%h want 0/0", busy, product);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin tick(); if (done) dc++; end
    vectors++; if (dc !== 0) begin miscompares++; $display("FAIL midreset_done: got %0d pulses want 0", dc); end
    run_one(32'd7, 32'd9, lat, bc, dc2, pd, pa, ba);
    pop_expected(expv);
    vectors++; if (pd !== 64'd63 || pd !== expv || lat !== 33) begin
      miscompares++; $display("FAIL midreset_rerun: got %h lat=%0d want 3f lat=33", pd, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n = 1000;
    int gap;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    start = 1'b1; multiplicand = a; multiplier = b;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    for (int k = 0; k < n; k++) begin
      gap = 0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (done) begin gap = i; break; end
      end
      pop_expected(expv);
      vectors++; if (gap == 0 || product !== expv) begin
        miscompares++; $display("FAIL b2b_product[%0d]: got %h want %h gap=%0d", k, product, expv, gap);
      end
      if (k != 0) begin
        vectors++; if (gap !== 34) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %0d want 34", k, gap); end
      end
      if (gap == 0) begin start = 1'b0; break; end
      if (k == n - 1) begin
        start = 1'b0;
      end else begin
        a = $urandom; b = $urandom;
        if (k % 97 == 0) a = 32'hFFFF_FFFF;
        multiplicand = a; multiplier = b;
        exp_q.push_back({32'd0, a} * {32'd0, b});
      end
    end
    tick(); tick();
    vectors++; if (busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL b2b_drain: got busy=%b queued=%0d want 0/0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_start_while_busy();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
